// File: rtl/estacionamiento_pkg.sv
// rtl/estacionamiento_pkg.sv - shared constants and state encoding for the parking barrier
package estacionamiento_pkg;

  localparam int F_CLK_HZ      = 12_000_000;
  localparam int CAPACIDAD_DEF = 7;
  localparam int T_ABIERTA_DEF = F_CLK_HZ;
  localparam int T_CIERRE_DEF  = F_CLK_HZ / 2;

  localparam logic [1:0] EST_REPOSO      = 2'd0;
  localparam logic [1:0] EST_ABIERTA_ENT = 2'd1;
  localparam logic [1:0] EST_ABIERTA_SAL = 2'd2;
  localparam logic [1:0] EST_CIERRE      = 2'd3;

  typedef enum logic [1:0] {
    REPOSO      = EST_REPOSO,
    ABIERTA_ENT = EST_ABIERTA_ENT,
    ABIERTA_SAL = EST_ABIERTA_SAL,
    CIERRE      = EST_CIERRE
  } estado_t;

  // Timer width covering the longer of the two windows, never below 1 bit.
  function automatic int ancho_timer(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/temporizador.sv
// rtl/temporizador.sv - clearable saturating up-counter with compare-to-limit
module temporizador #(
  parameter int ANCHO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             limpiar,
  input  logic [ANCHO-1:0] limite,
  output logic             expiro
);

  logic [ANCHO-1:0] cuenta;

  // Saturates at all-ones so a long stay in one state never wraps into a false expiry.
  always_ff @(posedge clk) begin
    if (rst || limpiar) begin
      cuenta <= '0;
    end else if (cuenta != '1) begin
      cuenta <= cuenta + 1'b1;
    end
  end

  assign expiro = (cuenta == limite);

endmodule

// File: rtl/controlador_barrera.sv
// rtl/controlador_barrera.sv - shared entry/exit barrier sequencer with round-robin grant
module controlador_barrera
  import estacionamiento_pkg::*;
#(
  parameter int ANCHO_OCUP = 3,
  parameter int CAPACIDAD  = CAPACIDAD_DEF,
  parameter int T_ABIERTA  = T_ABIERTA_DEF,
  parameter int T_CIERRE   = T_CIERRE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_entrada,
  input  logic                  req_salida,
  input  logic                  paso_entrada,
  input  logic                  paso_salida,
  input  logic [ANCHO_OCUP-1:0] ocupacion,
  output logic                  barrera_abrir,
  output logic                  verde_entrada,
  output logic                  verde_salida,
  output logic                  lleno,
  output logic                  timeout
);

  localparam int TW = ancho_timer(T_ABIERTA, T_CIERRE);

  estado_t       estado, estado_sig;
  logic          ultimo_salida, ultimo_salida_sig;
  logic          timeout_sig;
  logic          lleno_int;
  logic          elig_ent, elig_sal;
  logic          limpiar, expiro;
  logic [TW-1:0] limite;

  assign lleno_int = (32'(ocupacion) >= $unsigned(CAPACIDAD));
  assign elig_ent  = req_entrada && !lleno_int;
  assign elig_sal  = req_salida;
  assign limite    = (estado == CIERRE) ? TW'(T_CIERRE - 1) : TW'(T_ABIERTA - 1);
  // Restarting the count on every state change gives each window its own origin at 0.
  assign limpiar   = (estado_sig != estado);

  temporizador #(
    .ANCHO (TW)
  ) u_temporizador (
    .clk     (clk),
    .rst     (rst),
    .limpiar (limpiar),
    .limite  (limite),
    .expiro  (expiro)
  );

  always_comb begin
    estado_sig        = estado;
    ultimo_salida_sig = ultimo_salida;
    timeout_sig       = 1'b0;
    case (estado)
      REPOSO: begin
        // On a tie the lane not served last wins.
        if (elig_ent && (!elig_sal || ultimo_salida)) begin
          estado_sig        = ABIERTA_ENT;
          ultimo_salida_sig = 1'b0;
        end else if (elig_sal) begin
          estado_sig        = ABIERTA_SAL;
          ultimo_salida_sig = 1'b1;
        end
      end
      ABIERTA_ENT: begin
        if (paso_entrada) begin
          estado_sig = CIERRE;
        end else if (expiro) begin
          estado_sig  = CIERRE;
          timeout_sig = 1'b1;
        end
      end
      ABIERTA_SAL: begin
        if (paso_salida) begin
          estado_sig = CIERRE;
        end else if (expiro) begin
          estado_sig  = CIERRE;
          timeout_sig = 1'b1;
        end
      end
      CIERRE: begin
        if (expiro) begin
          estado_sig = REPOSO;
        end
      end
      default: estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado        <= REPOSO;
      ultimo_salida <= 1'b1;
      barrera_abrir <= 1'b0;
      verde_entrada <= 1'b0;
      verde_salida  <= 1'b0;
      lleno         <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      estado        <= estado_sig;
      ultimo_salida <= ultimo_salida_sig;
      barrera_abrir <= (estado_sig == ABIERTA_ENT) || (estado_sig == ABIERTA_SAL);
      verde_entrada <= (estado_sig == ABIERTA_ENT);
      verde_salida  <= (estado_sig == ABIERTA_SAL);
      lleno         <= lleno_int;
      timeout       <= timeout_sig;
    end
  end

endmodule

// File: tb/tb_controlador_barrera.sv
// tb/tb_controlador_barrera.sv - randomized bench for controlador_barrera against a lane/cycle model
module tb_controlador_barrera;

  localparam int CAP = 3;
  localparam int TA  = 8;
  localparam int TC  = 4;

  logic       clk;
  logic       rst;
  logic       req_entrada, req_salida, paso_entrada, paso_salida;
  logic [2:0] ocupacion;
  logic       barrera_abrir, verde_entrada, verde_salida, lleno, timeout;

  int checks = 0;
  int errors = 0;

  controlador_barrera #(
    .ANCHO_OCUP (3),
    .CAPACIDAD  (CAP),
    .T_ABIERTA  (TA),
    .T_CIERRE   (TC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_entrada   (req_entrada),
    .req_salida    (req_salida),
    .paso_entrada  (paso_entrada),
    .paso_salida   (paso_salida),
    .ocupacion     (ocupacion),
    .barrera_abrir (barrera_abrir),
    .verde_entrada (verde_entrada),
    .verde_salida  (verde_salida),
    .lleno         (lleno),
    .timeout       (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: which lane is open (0 none, 1 entry, 2 exit), open cycles seen, closing cycles left.
  int  m_lane    = 0;
  int  m_abiertos = 0;
  int  m_cierre  = 0;
  bit  m_ult_sal = 1'b1;
  bit  e_to      = 1'b0;
  bit  e_lleno   = 1'b0;
  bit  armado    = 1'b0;

  always @(posedge clk) begin
    bit pide_e;
    bit pide_s;
    if (rst) begin
      m_lane = 0; m_abiertos = 0; m_cierre = 0; m_ult_sal = 1'b1;
      e_to = 1'b0; e_lleno = 1'b0; armado = 1'b1;
    end else begin
      e_to = 1'b0;
      if (m_lane != 0) begin
        m_abiertos = m_abiertos + 1;
        if ((m_lane == 1 && paso_entrada) || (m_lane == 2 && paso_salida)) begin
          m_lane = 0; m_cierre = TC;
        end else if (m_abiertos == TA) begin
          m_lane = 0; m_cierre = TC; e_to = 1'b1;
        end
      end else if (m_cierre > 0) begin
        m_cierre = m_cierre - 1;
      end else begin
        pide_e = req_entrada && (int'(ocupacion) < CAP);
        pide_s = req_salida;
        if (pide_e && pide_s) m_lane = m_ult_sal ? 1 : 2;
        else if (pide_e)      m_lane = 1;
        else if (pide_s)      m_lane = 2;
        if (m_lane != 0) begin
          m_ult_sal  = (m_lane == 2);
          m_abiertos = 0;
        end
      end
      e_lleno = (int'(ocupacion) >= CAP);
    end
  end

  always @(negedge clk) begin
    logic [4:0] got, exp;
    if (armado) begin
      got = {barrera_abrir, verde_entrada, verde_salida, lleno, timeout};
      exp = {m_lane != 0, m_lane == 1, m_lane == 2, e_lleno, e_to};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL modelo t=%0t got(abr,ve,vs,ll,to)=%b expected=%b", $time, got, exp);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nombre, input int actual, input int esperado);
    checks++;
    if (actual != esperado) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nombre, actual, esperado);
    end
  endtask

  task automatic wait_grant(input string nombre, output int lane);
    bit hallado;
    hallado = 1'b0;
    lane = 0;
    for (int i = 0; i < 40 && !hallado; i++) begin
      if (barrera_abrir) begin
        hallado = 1'b1;
        lane = verde_entrada ? 1 : (verde_salida ? 2 : 3);
      end else begin
        tick();
      end
    end
    if (!hallado) begin
      checks++;
      errors++;
      $display("FAIL %s grant wait expired got=0 expected=1", nombre);
    end
  endtask

  initial begin
    int lane;
    int abiertos;
    bit cerrado;
    rst = 1'b1; req_entrada = 0; req_salida = 0; paso_entrada = 0; paso_salida = 0; ocupacion = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_salidas", {barrera_abrir, verde_entrada, verde_salida, lleno, timeout}, 0);

    // 1: grant latency
    req_entrada = 1;
    tick();
    chk("grant_barrera", barrera_abrir, 1);
    chk("grant_verde_ent", verde_entrada, 1);
    req_entrada = 0;

    // 2: pass on open cycle 3, then closing hold
    tick(); tick();
    paso_entrada = 1;
    tick();
    paso_entrada = 0;
    chk("cierre_tras_paso", barrera_abrir, 0);
    for (int k = 0; k < TC; k++) begin
      chk("cierre_sostenido", barrera_abrir, 0);
      chk("cierre_sin_timeout", timeout, 0);
      tick();
    end

    // 3: continuous tie alternates, exit first since entry was served last
    req_entrada = 1; req_salida = 1;
    for (int g = 0; g < 4; g++) begin
      wait_grant("rr", lane);
      chk("rr_carril", lane, (g % 2 == 0) ? 2 : 1);
      if (lane == 1) paso_entrada = 1; else paso_salida = 1;
      tick();
      paso_entrada = 0; paso_salida = 0;
    end
    req_entrada = 0; req_salida = 0;
    repeat (8) tick();

    // 4: full lot blocks entry, not exit
    ocupacion = 3'd3; req_entrada = 1;
    tick();
    chk("lleno", lleno, 1);
    for (int k = 0; k < 20; k++) begin
      chk("lleno_sin_grant", barrera_abrir, 0);
      tick();
    end
    req_salida = 1;
    wait_grant("lleno_salida", lane);
    chk("lleno_salida_carril", lane, 2);
    paso_salida = 1;
    tick();
    paso_salida = 0; req_entrada = 0; req_salida = 0; ocupacion = 0;
    repeat (6) tick();

    // 5: open window expiry
    req_entrada = 1;
    wait_grant("expira", lane);
    req_entrada = 0;
    abiertos = 1; cerrado = 0;
    for (int k = 0; k < 20 && !cerrado; k++) begin
      tick();
      if (barrera_abrir) abiertos++; else cerrado = 1;
    end
    chk("ciclos_abiertos", abiertos, TA);
    chk("timeout_pulso", timeout, 1);
    tick();
    chk("timeout_un_ciclo", timeout, 0);
    repeat (6) tick();
    req_entrada = 1;
    wait_grant("paso_en_expiro", lane);
    req_entrada = 0;
    repeat (TA - 1) tick();
    paso_entrada = 1;
    tick();
    paso_entrada = 0;
    chk("paso_gana_timeout", timeout, 0);
    chk("paso_gana_cierre", barrera_abrir, 0);
    repeat (6) tick();

    // 6: reset during exit window
    req_salida = 1;
    wait_grant("rst_abierta", lane);
    chk("rst_abierta_carril", lane, 2);
    req_salida = 0;
    tick();
    rst = 1;
    tick();
    chk("rst_cierra", barrera_abrir, 0);
    chk("rst_sin_timeout", timeout, 0);
    rst = 0; req_entrada = 1; req_salida = 1;
    wait_grant("rst_empate", lane);
    chk("rst_empate_entrada", lane, 1);
    paso_entrada = 1;
    tick();
    paso_entrada = 0; req_entrada = 0; req_salida = 0;

    // Randomized traffic checked only by the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) req_entrada = ~req_entrada;
      if ($urandom_range(0, 9) == 0) req_salida = ~req_salida;
      paso_entrada = ($urandom_range(0, 7) == 0);
      paso_salida  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) ocupacion = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
